// File: rtl/handshake_interconnect_pkg.sv
// Shared types for the single-master handshake interconnect: FSM states and
// fault cause codes reported on err_cause.
package handshake_interconnect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNMAPPED = 2'd1,
    ERR_RO_WRITE = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_cause_e;

endpackage

// File: rtl/region_decoder.sv
// Combinational address decoder: finds the lowest-indexed region whose
// [base, end) window contains the address and reports its index and base.
module region_decoder #(
  parameter int REGIONS = 5,
  parameter int ADDR_W  = 32,
  parameter int IDX_W   = (REGIONS > 1) ? $clog2(REGIONS) : 1
) (
  input  logic [ADDR_W-1:0]         addr,
  input  logic [REGIONS*ADDR_W-1:0] region_base,
  input  logic [REGIONS*ADDR_W-1:0] region_end,
  output logic                      hit,
  output logic [IDX_W-1:0]          index,
  output logic [ADDR_W-1:0]         base
);

  always_comb begin
    hit   = 1'b0;
    index = '0;
    base  = '0;
    // Scan from the top down so the lowest hitting index overrides on overlap.
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if ((addr >= region_base[i*ADDR_W +: ADDR_W]) &&
          (addr <  region_end[i*ADDR_W +: ADDR_W])) begin
        hit   = 1'b1;
        index = IDX_W'(i);
        base  = region_base[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/handshake_interconnect.sv
// Single-master, N-slave interconnect: decodes the master address, issues a
// one-cycle slave request, waits for ack with a watchdog and returns a response.
module handshake_interconnect
  import handshake_interconnect_pkg::*;
#(
  parameter int                 REGIONS = 5,
  parameter int                 ADDR_W  = 32,
  parameter int                 DATA_W  = 32,
  parameter logic [REGIONS-1:0] RO_MASK = 5'b11001,
  parameter int                 TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_m,
  input  logic                      we_m,
  input  logic [ADDR_W-1:0]         addr_m,
  input  logic [DATA_W-1:0]         wd_m,
  output logic [DATA_W-1:0]         rd_m,
  output logic                      rvalid_m,
  output logic                      err_m,
  input  logic [REGIONS*ADDR_W-1:0] region_base,
  input  logic [REGIONS*ADDR_W-1:0] region_end,
  output logic [REGIONS-1:0]        req_s,
  output logic                      we_s,
  output logic [ADDR_W-1:0]         addr_s,
  output logic [DATA_W-1:0]         wd_s,
  input  logic [REGIONS*DATA_W-1:0] rd_s,
  input  logic [REGIONS-1:0]        ack_s,
  output logic [ADDR_W-1:0]         err_addr,
  output logic [1:0]                err_cause
);

  localparam int IDX_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);

  state_e             state_q, state_d;
  err_cause_e         err_cause_q, err_cause_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [REGIONS-1:0] req_s_q, req_s_d;
  logic               we_s_q, we_s_d;
  logic [ADDR_W-1:0]  addr_s_q, addr_s_d;
  logic [DATA_W-1:0]  wd_s_q, wd_s_d;
  logic [DATA_W-1:0]  rd_q, rd_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  err_addr_q, err_addr_d;
  logic [ADDR_W-1:0]  cap_addr_q, cap_addr_d;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic [ADDR_W-1:0]  dec_base;

  region_decoder #(
    .REGIONS (REGIONS),
    .ADDR_W  (ADDR_W),
    .IDX_W   (IDX_W)
  ) u_region_decoder (
    .addr        (addr_m),
    .region_base (region_base),
    .region_end  (region_end),
    .hit         (dec_hit),
    .index       (dec_idx),
    .base        (dec_base)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    timer_d     = timer_q;
    req_s_d     = '0;
    we_s_d      = 1'b0;
    addr_s_d    = addr_s_q;
    wd_s_d      = wd_s_q;
    rd_d        = rd_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    err_cause_d = err_cause_q;
    cap_addr_d  = cap_addr_q;

    case (state_q)
      IDLE: begin
        if (req_m) begin
          if (dec_hit && !(we_m && RO_MASK[dec_idx])) begin
            sel_d            = dec_idx;
            req_s_d[dec_idx] = 1'b1;
            we_s_d           = we_m;
            wd_s_d           = wd_m;
            addr_s_d         = addr_m - dec_base;
            cap_addr_d       = addr_m;
            timer_d          = '0;
            state_d          = WAIT;
          end else begin
            rd_d        = '0;
            err_d       = 1'b1;
            err_addr_d  = addr_m;
            err_cause_d = dec_hit ? ERR_RO_WRITE : ERR_UNMAPPED;
            state_d     = RESP;
          end
        end
      end
      WAIT: begin
        // An ack in the final watchdog cycle still completes normally.
        if (ack_s[sel_q]) begin
          rd_d    = rd_s[int'(sel_q)*DATA_W +: DATA_W];
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          rd_d        = '0;
          err_d       = 1'b1;
          err_addr_d  = cap_addr_q;
          err_cause_d = ERR_TIMEOUT;
          state_d     = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      timer_q     <= '0;
      req_s_q     <= '0;
      we_s_q      <= 1'b0;
      addr_s_q    <= '0;
      wd_s_q      <= '0;
      rd_q        <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      err_cause_q <= ERR_NONE;
      cap_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      timer_q     <= timer_d;
      req_s_q     <= req_s_d;
      we_s_q      <= we_s_d;
      addr_s_q    <= addr_s_d;
      wd_s_q      <= wd_s_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      err_cause_q <= err_cause_d;
      cap_addr_q  <= cap_addr_d;
    end
  end

  assign rd_m      = rd_q;
  assign rvalid_m  = (state_q == RESP);
  assign err_m     = err_q;
  assign req_s     = req_s_q;
  assign we_s      = we_s_q;
  assign addr_s    = addr_s_q;
  assign wd_s      = wd_s_q;
  assign err_addr  = err_addr_q;
  assign err_cause = err_cause_q;

endmodule

// File: tb/tb_handshake_interconnect.sv
// Bench for handshake_interconnect: transaction-level reference model with a
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_handshake_interconnect;

  localparam int REGIONS = 5;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 64;
  localparam logic [REGIONS-1:0] RO = 5'b11001;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_m, we_m;
  logic [AW-1:0]         addr_m;
  logic [DW-1:0]         wd_m;
  logic [DW-1:0]         rd_m;
  logic                  rvalid_m, err_m;
  logic [REGIONS*AW-1:0] region_base, region_end;
  logic [REGIONS-1:0]    req_s;
  logic                  we_s;
  logic [AW-1:0]         addr_s;
  logic [DW-1:0]         wd_s;
  logic [REGIONS*DW-1:0] rd_s;
  logic [REGIONS-1:0]    ack_s;
  logic [AW-1:0]         err_addr;
  logic [1:0]            err_cause;

  handshake_interconnect #(
    .REGIONS (REGIONS), .ADDR_W (AW), .DATA_W (DW), .RO_MASK (RO), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .reset (reset), .req_m (req_m), .we_m (we_m), .addr_m (addr_m),
    .wd_m (wd_m), .rd_m (rd_m), .rvalid_m (rvalid_m), .err_m (err_m),
    .region_base (region_base), .region_end (region_end), .req_s (req_s),
    .we_s (we_s), .addr_s (addr_s), .wd_s (wd_s), .rd_s (rd_s), .ack_s (ack_s),
    .err_addr (err_addr), .err_cause (err_cause)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs for the current cycle, maintained by the stimulus process.
  logic               chk_en = 1'b0;
  logic               exp_rvalid, exp_err, exp_we_s;
  logic [DW-1:0]      exp_rd, exp_wd_s;
  logic [REGIONS-1:0] exp_req_s;
  logic [AW-1:0]      exp_addr_s, exp_err_addr;
  logic [1:0]         exp_err_cause;

  // DUT observations captured during a transaction for directed checks.
  int                 lat_dut;
  logic               seen_err, seen_we_s;
  logic [REGIONS-1:0] seen_req_s;
  logic [AW-1:0]      seen_addr_s;
  logic [DW-1:0]      seen_wd_s;

  logic               rd_fix_en = 1'b0;
  logic [DW-1:0]      rd_fix;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rvalid_m", 64'(rvalid_m), 64'(exp_rvalid));
      if (exp_rvalid) chk("err_m", 64'(err_m), 64'(exp_err));
      chk("rd_m", 64'(rd_m), 64'(exp_rd));
      chk("req_s", 64'(req_s), 64'(exp_req_s));
      chk("we_s", 64'(we_s), 64'(exp_we_s));
      if (exp_req_s != '0) begin
        chk("addr_s", 64'(addr_s), 64'(exp_addr_s));
        chk("wd_s", 64'(wd_s), 64'(exp_wd_s));
      end
      chk("err_addr", 64'(err_addr), 64'(exp_err_addr));
      chk("err_cause", 64'(err_cause), 64'(exp_err_cause));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_region(input int i, input logic [AW-1:0] b, input logic [AW-1:0] e);
    region_base[i*AW +: AW] = b;
    region_end[i*AW +: AW]  = e;
  endtask

  function automatic int model_decode(input logic [AW-1:0] a);
    for (int i = 0; i < REGIONS; i++)
      if (a >= region_base[i*AW +: AW] && a < region_end[i*AW +: AW]) return i;
    return -1;
  endfunction

  task automatic exp_clear_all();
    exp_rvalid = 1'b0; exp_err = 1'b0; exp_rd = '0; exp_req_s = '0; exp_we_s = 1'b0;
    exp_addr_s = '0; exp_wd_s = '0; exp_err_addr = '0; exp_err_cause = 2'd0;
  endtask

  task automatic drive_slaves(input int sel, input logic ack_sel);
    for (int i = 0; i < REGIONS; i++) begin
      rd_s[i*DW +: DW] = $urandom;
      if (i == sel) ack_s[i] = ack_sel;
      else          ack_s[i] = ($urandom_range(0, 3) == 0);
    end
    if (rd_fix_en && sel >= 0) rd_s[sel*DW +: DW] = rd_fix;
  endtask

  task automatic note_rvalid(input int k);
    if (rvalid_m === 1'b1 && lat_dut < 0) begin
      lat_dut  = k;
      seen_err = err_m;
    end
  endtask

  task automatic idle(input int n);
    req_m = 1'b0;
    for (int k = 0; k < n; k++) begin
      drive_slaves(-1, 1'b0);
      step();
    end
  endtask

  // dly: WAIT-cycle index at which the selected slave acks; negative = never.
  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input int dly, input logic keep);
    int idx, n;
    logic done;
    logic [DW-1:0] cap;
    idx = model_decode(addr);
    req_m = 1'b1; we_m = we; addr_m = addr; wd_m = wd;
    drive_slaves(-1, 1'b0);
    lat_dut = -1; seen_err = 1'b0;
    step();
    note_rvalid(1);
    seen_req_s = req_s; seen_we_s = we_s; seen_addr_s = addr_s; seen_wd_s = wd_s;
    if (idx < 0 || (we && RO[idx])) begin
      exp_req_s = '0; exp_we_s = 1'b0;
      exp_rvalid = 1'b1; exp_err = 1'b1; exp_rd = '0;
      exp_err_addr = addr; exp_err_cause = (idx < 0) ? 2'd1 : 2'd2;
    end else begin
      exp_req_s = '0; exp_req_s[idx] = 1'b1; exp_we_s = we;
      exp_addr_s = addr - region_base[idx*AW +: AW]; exp_wd_s = wd;
      exp_rvalid = 1'b0;
      n = 0; done = 1'b0;
      while (!done) begin
        drive_slaves(idx, n == dly);
        cap = rd_s[idx*DW +: DW];
        step();
        note_rvalid(n + 2);
        exp_req_s = '0; exp_we_s = 1'b0;
        if (n == dly) begin
          exp_rvalid = 1'b1; exp_err = 1'b0; exp_rd = cap; done = 1'b1;
        end else if (n == TIMEOUT - 1) begin
          exp_rvalid = 1'b1; exp_err = 1'b1; exp_rd = '0;
          exp_err_addr = addr; exp_err_cause = 2'd3; done = 1'b1;
        end
        n++;
      end
    end
    if (!keep) req_m = 1'b0;
    drive_slaves(-1, 1'b0);
    step();
    exp_rvalid = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    logic [AW-1:0] b, e;
    r = $urandom_range(0, REGIONS);
    if (r == REGIONS) begin
      case ($urandom_range(0, 2))
        0:       return 32'h3000 + $urandom_range(0, 32'hCFFF);
        1:       return 32'h90000 + $urandom_range(0, 255);
        default: return 32'hFFFF_FFFC;
      endcase
    end
    b = region_base[r*AW +: AW];
    e = region_end[r*AW +: AW];
    case ($urandom_range(0, 3))
      0:       return b;
      1:       return e - 1;
      2:       return e;
      default: return b + $urandom_range(0, e - b - 1);
    endcase
  endfunction

  task automatic random_phase(input int count);
    logic keep;
    int dly;
    for (int t = 0; t < count; t++) begin
      keep = 1'($urandom_range(0, 1));
      dly  = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 4));
      txn(1'($urandom_range(0, 1)), rand_addr(), $urandom, dly, keep);
      if (!keep) idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_m = 1'b0; we_m = 1'b0; addr_m = '0; wd_m = '0;
    rd_s = '0; ack_s = '0;
    set_region(0, 32'h0000_0000, 32'h0000_1000);
    set_region(1, 32'h0000_1000, 32'h0000_2000);
    set_region(2, 32'h0000_2000, 32'h0000_3000);
    set_region(3, 32'h0001_0000, 32'h0005_0000);
    set_region(4, 32'h0005_0000, 32'h0009_0000);
    step();
    step();
    exp_clear_all();
    chk_en = 1'b1;
    chk("rst_rvalid", 64'(rvalid_m), 64'd0);
    chk("rst_err_m", 64'(err_m), 64'd0);
    chk("rst_addr_s", 64'(addr_s), 64'd0);
    chk("rst_wd_s", 64'(wd_s), 64'd0);
    reset = 1'b0;
    idle(2);

    // Read 0x1004, slave 1 acks one cycle after its request.
    rd_fix_en = 1'b1; rd_fix = 32'hDEAD_BEEF;
    txn(1'b0, 32'h0000_1004, 32'h0, 1, 1'b0);
    rd_fix_en = 1'b0;
    chk("rd_req_s", 64'(seen_req_s), 64'b00010);
    chk("rd_addr_s", 64'(seen_addr_s), 64'h4);
    chk("rd_latency", 64'(lat_dut), 64'd3);
    chk("rd_err", 64'(seen_err), 64'd0);
    chk("rd_data", 64'(rd_m), 64'hDEAD_BEEF);
    idle(1);

    // Write 0x1008 into region 1.
    txn(1'b1, 32'h0000_1008, 32'h1234_5678, 0, 1'b0);
    chk("wr_req_s", 64'(seen_req_s), 64'b00010);
    chk("wr_we_s", 64'(seen_we_s), 64'd1);
    chk("wr_wd_s", 64'(seen_wd_s), 64'h1234_5678);
    chk("wr_addr_s", 64'(seen_addr_s), 64'h8);
    chk("wr_latency", 64'(lat_dut), 64'd2);
    chk("wr_err", 64'(seen_err), 64'd0);

    // Write to read-only region 0.
    txn(1'b1, 32'h0000_0010, 32'hCAFE_0000, 0, 1'b0);
    chk("ro_req_s", 64'(seen_req_s), 64'd0);
    chk("ro_latency", 64'(lat_dut), 64'd1);
    chk("ro_err", 64'(seen_err), 64'd1);
    chk("ro_cause", 64'(err_cause), 64'd2);
    chk("ro_addr", 64'(err_addr), 64'h10);

    // Unmapped read.
    txn(1'b0, 32'h0000_4000, 32'h0, 0, 1'b1);
    chk("um_err", 64'(seen_err), 64'd1);
    chk("um_rd", 64'(rd_m), 64'd0);
    chk("um_cause", 64'(err_cause), 64'd1);
    chk("um_addr", 64'(err_addr), 64'h4000);

    // PIO never acks: watchdog fires, a late ack is then ignored.
    txn(1'b0, 32'h0000_2000, 32'h0, -1, 1'b0);
    chk("to_latency", 64'(lat_dut), 64'(TIMEOUT + 1));
    chk("to_err", 64'(seen_err), 64'd1);
    chk("to_cause", 64'(err_cause), 64'd3);
    chk("to_addr", 64'(err_addr), 64'h2000);
    req_m = 1'b0; ack_s = '1;
    step();
    chk("to_late_ack", 64'(rvalid_m), 64'd0);
    txn(1'b0, 32'h0000_1004, 32'h0, 0, 1'b0);
    chk("after_to_err", 64'(seen_err), 64'd0);
    chk("after_to_req_s", 64'(seen_req_s), 64'b00010);
    chk("sticky_cause", 64'(err_cause), 64'd3);

    // Ack in the last watchdog cycle wins over the timeout.
    txn(1'b0, 32'h0000_2004, 32'h0, TIMEOUT - 1, 1'b0);
    chk("edge_latency", 64'(lat_dut), 64'(TIMEOUT + 1));
    chk("edge_err", 64'(seen_err), 64'd0);
    idle(1);

    // Reset while waiting on the slave; the following ack must be dropped.
    req_m = 1'b1; we_m = 1'b0; addr_m = 32'h0000_2000; wd_m = 32'hA5A5_0000;
    drive_slaves(-1, 1'b0);
    step();
    exp_req_s = 5'b00100; exp_we_s = 1'b0; exp_addr_s = '0; exp_wd_s = 32'hA5A5_0000;
    drive_slaves(2, 1'b0);
    step();
    exp_req_s = '0;
    reset = 1'b1;
    drive_slaves(2, 1'b0);
    step();
    exp_clear_all();
    reset = 1'b0; req_m = 1'b0; ack_s = '1;
    chk("rw_addr_s", 64'(addr_s), 64'd0);
    chk("rw_wd_s", 64'(wd_s), 64'd0);
    step();
    chk("rw_no_rvalid", 64'(rvalid_m), 64'd0);
    idle(2);

    random_phase(300);

    // Overlapping map: region 2 now starts inside region 1.
    idle(1);
    set_region(2, 32'h0000_1800, 32'h0000_3000);
    txn(1'b0, 32'h0000_1900, 32'h0, 0, 1'b0);
    chk("ovl_req_s", 64'(seen_req_s), 64'b00010);
    chk("ovl_addr_s", 64'(seen_addr_s), 64'h900);
    txn(1'b1, 32'h0000_2100, 32'h5555_AAAA, 1, 1'b0);
    chk("ovl2_req_s", 64'(seen_req_s), 64'b00100);
    chk("ovl2_addr_s", 64'(seen_addr_s), 64'h900);
    random_phase(100);
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
